mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Moore-style control FSM that sequences a multicycle MIPS datapath: one shared instruction/data memory, an instruction register, ALUOut/Data registers, and a single ALU reused for PC+4, branch target and execution.
- Replaces the single-cycle controller/maindec/aludec trio.
- Supports lw, sw, R-type (add/sub/and/or/slt), beq, bne, addi, andi, ori, xori and j.
- Memory accesses use a ready handshake so slow memories can insert wait states.

Parameters:
- ST_W, 4, width of state register and dbg_state output.

Ports:
- clk  in  1  system clock, all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces state to FETCH
- op  in  6  instr[31:26], taken from the instruction register
- funct  in  6  instr[5:0], taken from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completed the current access this cycle
- iord  out  1  0 = address memory with PC, 1 = address memory with ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load enable
- regdst  out  1  1 = write rd, 0 = write rt
- memtoreg  out  1  1 = writeback Data register, 0 = writeback ALUOut
- regwrite  out  1  register file write enable
- alusrca  out  1  0 = PC, 1 = register A
- alusrcb  out  2  00 = B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2
- pcsrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 011 xor, 111 slt
- pcen  out  1  PC register load enable
- illegal  out  1  undefined opcode or funct detected (see Optional Feature)
- dbg_state  out  ST_W  current state encoding

Behaviour:
- States and encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5
  - EXEC=6, ALUWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11, TRAP=12
- Outputs not listed for a state are 0. alucontrol defaults to 010.
- FETCH:
  - iord=0, alusrca=0, alusrcb=01, pcsrc=00
  - irwrite=pcen=mem_ready
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE:
  - alusrca=0, alusrcb=11, add (branch target latched in ALUOut)
  - Next state by op:
    - 100011/101011 -> MEMADR
    - 000000 -> EXEC if funct is one of 100000, 100010, 100100, 100101, 101010; otherwise undefined
    - 000100/000101 -> BRANCH
    - 001000/001100/001101/001110 -> IMMEX
    - 000010 -> JUMP
    - anything else -> undefined
- MEMADR: alusrca=1, alusrcb=10, add. Next is MEMRD for op 100011, MEMWR for op 101011.
- MEMRD: iord=1. Hold until mem_ready=1, then MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1; then FETCH.
- MEMWR:
  - iord=1, memwrite=1
  - memwrite stays asserted with stable address/data while mem_ready=0
  - mem_ready=1 -> FETCH
- EXEC: alusrca=1, alusrcb=00, alucontrol from funct (add 010, sub 110, and 000, or 001, slt 111); then ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1; then FETCH.
- BRANCH:
  - alusrca=1, alusrcb=00, sub, pcsrc=01
  - pcen = zero XOR op[0]: beq taken on equal, bne taken on not-equal
  - Then FETCH.
- IMMEX: alusrca=1, alusrcb=10, alucontrol by op (addi 010, andi 000, ori 001, xori 011); then IMMWB.
- IMMWB: regdst=0, memtoreg=0, regwrite=1; then FETCH.
- JUMP: pcsrc=10, pcen=1; then FETCH.
- Latency in cycles, excluding wait states:
  - lw 5
  - sw, R-type, addi/andi/ori/xori 4
  - beq, bne, j 3
- Each wait cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
- Reset:
  - While reset=1: state=FETCH; pcen, irwrite, regwrite and memwrite are forced to 0; illegal=0; dbg_state=0.
  - Asserting reset in any state, including mid-wait in MEMWR, aborts the instruction immediately with no further writes.
  - First fetch starts on the first rising edge after reset deasserts.
- mem_ready is ignored in all states except FETCH, MEMRD and MEMWR.

Optional Feature:
- Macro MC_ILLEGAL_TRAP_EN.
- Defined:
  - An undefined op/funct in DECODE goes to TRAP.
  - TRAP asserts illegal=1, holds all write enables at 0, and is left only by reset.
- Undefined:
  - An undefined op/funct in DECODE goes to FETCH (executes as a 2-cycle NOP).
  - TRAP is unreachable; illegal is tied to 0.

Test Plan:
- Reset, then lw (op 100011) with mem_ready held low 2 cycles in FETCH and 1 cycle in MEMRD -> dbg_state sequence 0,0,0,1,2,3,3,4,0; regwrite=1 and memtoreg=1 only in state 4.
- bne (op 000101) with zero=0 -> pcen=1 and pcsrc=01 in BRANCH; same instruction with zero=1 -> pcen=0; beq gives the opposite results.
- R-type funct 101010 -> alucontrol=111 in EXEC, regdst=1 and regwrite=1 in ALUWB; xori (op 001110) -> alucontrol=011 in IMMEX.
- sw with mem_ready=0 for 3 cycles in MEMWR -> memwrite=1 and iord=1 for 4 consecutive cycles, then FETCH.
- op 111111, with and without MC_ILLEGAL_TRAP_EN:
  - Defined: state reaches 12, illegal=1, state held for 10 cycles.
  - Undefined: state returns to 0, illegal=0.
- reset pulsed while in MEMWR -> memwrite drops asynchronously the same cycle; dbg_state=0; next fetch occurs after deassert.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: Moore-style control FSM for a multicycle MIPS datapath with one
// shared instruction/data memory and a single reused ALU. Memory accesses in
// FETCH, MEMRD and MEMWR wait for mem_ready.
// Optional feature: define MC_ILLEGAL_TRAP_EN to send undefined op/funct
// codes to a TRAP state that raises 'illegal' until reset. Without it,
// undefined codes retire as a two-cycle NOP and 'illegal' is tied to 0.
module mc_ctrl #(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [5:0]      op,
    input  logic [5:0]      funct,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            iord,
    output logic            memwrite,
    output logic            irwrite,
    output logic            regdst,
    output logic            memtoreg,
    output logic            regwrite,
    output logic            alusrca,
    output logic [1:0]      alusrcb,
    output logic [1:0]      pcsrc,
    output logic [2:0]      alucontrol,
    output logic            pcen,
    output logic            illegal,
    output logic [ST_W-1:0] dbg_state
);

    typedef enum logic [ST_W-1:0] {
        FETCH  = ST_W'(0),
        DECODE = ST_W'(1),
        MEMADR = ST_W'(2),
        MEMRD  = ST_W'(3),
        MEMWB  = ST_W'(4),
        MEMWR  = ST_W'(5),
        EXEC   = ST_W'(6),
        ALUWB  = ST_W'(7),
        BRANCH = ST_W'(8),
        IMMEX  = ST_W'(9),
        IMMWB  = ST_W'(10),
        JUMP   = ST_W'(11),
        TRAP   = ST_W'(12)
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Where DECODE goes when the op/funct pair is not one we implement.
`ifdef MC_ILLEGAL_TRAP_EN
    localparam state_t UNDEF_NEXT = TRAP;
`else
    localparam state_t UNDEF_NEXT = FETCH;
`endif

    state_t     state_q, state_d;
    logic       funct_ok;
    logic [2:0] r_alu;
    logic [2:0] i_alu;
    logic       pcen_c, irwrite_c, regwrite_c, memwrite_c;

    // State register; reset returns the machine to FETCH immediately.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // R-type funct decode: ALU operation and whether the funct is supported.
    always_comb begin
        funct_ok = 1'b1;
        r_alu    = ALU_ADD;
        case (funct)
            6'b100000: r_alu = ALU_ADD;
            6'b100010: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b101010: r_alu = ALU_SLT;
            default:   funct_ok = 1'b0;
        endcase
    end

    // Immediate-op ALU selection from the opcode.
    always_comb begin
        i_alu = ALU_ADD;
        case (op)
            OP_ANDI: i_alu = ALU_AND;
            OP_ORI:  i_alu = ALU_OR;
            OP_XORI: i_alu = ALU_XOR;
            default: i_alu = ALU_ADD;
        endcase
    end

    // Next-state and Moore outputs; every state starts from the all-zero set.
    // NOTE: each signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        iord       = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite_c = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        alucontrol = ALU_ADD;
        pcen_c     = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            FETCH: begin
                alusrcb   = 2'b01;
                irwrite_c = mem_ready;
                pcen_c    = mem_ready;
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                // Branch target is computed speculatively and held in ALUOut.
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW:                      state_d = MEMADR;
                    OP_RTYPE:                          state_d = funct_ok ? EXEC : UNDEF_NEXT;
                    OP_BEQ, OP_BNE:                    state_d = BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_d = IMMEX;
                    OP_J:                              state_d = JUMP;
                    default:                           state_d = UNDEF_NEXT;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_c = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                // Strobe and address stay up for the whole wait.
                iord       = 1'b1;
                memwrite_c = 1'b1;
                if (mem_ready) state_d = FETCH;
            end
            EXEC: begin
                alusrca    = 1'b1;
                alucontrol = r_alu;
                state_d    = ALUWB;
            end
            ALUWB: begin
                regdst     = 1'b1;
                regwrite_c = 1'b1;
                state_d    = FETCH;
            end
            BRANCH: begin
                // op[0] distinguishes bne from beq and inverts the zero test.
                alusrca    = 1'b1;
                alucontrol = ALU_SUB;
                pcsrc      = 2'b01;
                pcen_c     = zero ^ op[0];
                state_d    = FETCH;
            end
            IMMEX: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = i_alu;
                state_d    = IMMWB;
            end
            IMMWB: begin
                regwrite_c = 1'b1;
                state_d    = FETCH;
            end
            JUMP: begin
                pcsrc   = 2'b10;
                pcen_c  = 1'b1;
                state_d = FETCH;
            end
            TRAP: begin
`ifdef MC_ILLEGAL_TRAP_EN
                illegal = 1'b1;
                state_d = TRAP;
`else
                state_d = FETCH;
`endif
            end
            default: state_d = FETCH;
        endcase
    end

    // Write enables are masked by reset so an abort cannot leak a write even
    // in FETCH, where irwrite/pcen follow mem_ready combinationally.
    assign pcen      = pcen_c     & ~reset;
    assign irwrite   = irwrite_c  & ~reset;
    assign regwrite  = regwrite_c & ~reset;
    assign memwrite  = memwrite_c & ~reset;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: self-checking bench for mc_ctrl. A reference model expands each
// instruction into its expected per-cycle control word from the instruction's
// class and requested wait states; directed and randomized instructions are
// then replayed against the DUT cycle by cycle.
`timescale 1ns/1ps
module tb_mc_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       pcen, illegal;
    logic [3:0] dbg_state;

    always #5 clk = ~clk;

    mc_ctrl #(.ST_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .iord(iord), .memwrite(memwrite),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .pcen(pcen),
        .illegal(illegal), .dbg_state(dbg_state)
    );

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000, OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI = 6'b001101, OP_XORI = 6'b001110, OP_BAD = 6'b111111;

    typedef struct packed {
        logic [3:0] st;
        logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] aluc;
        logic       pcen, illegal;
    } obs_t;

    typedef struct {
        obs_t       o;
        logic       mr;
        logic       z;
        logic [5:0] op;
        logic [5:0] funct;
    } ent_t;

    ent_t       q[$];
    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    logic [5:0] g_op, g_funct;
    logic       g_z;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o = '{st: dbg_state, iord: iord, memwrite: memwrite, irwrite: irwrite,
              regdst: regdst, memtoreg: memtoreg, regwrite: regwrite,
              alusrca: alusrca, alusrcb: alusrcb, pcsrc: pcsrc,
              aluc: alucontrol, pcen: pcen, illegal: illegal};
        return o;
    endfunction

    function automatic obs_t idle(input int st);
        obs_t o;
        o      = '0;
        o.st   = st[3:0];
        o.aluc = 3'b010;
        return o;
    endfunction

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic push(input obs_t o, input logic mr);
        ent_t e;
        e.o = o; e.mr = mr; e.z = g_z; e.op = g_op; e.funct = g_funct;
        q.push_back(e);
    endtask

    // Reference model: expand one instruction into expected cycles.
    task automatic gen_instr(input logic [5:0] op_v, input logic [5:0] funct_v,
                             input logic z, input int wf, input int wm);
        obs_t o;
        g_op = op_v; g_funct = funct_v; g_z = z;
        for (int i = 0; i <= wf; i++) begin
            o = idle(0); o.alusrcb = 2'b01;
            o.irwrite = (i == wf); o.pcen = (i == wf);
            push(o, i == wf);
        end
        o = idle(1); o.alusrcb = 2'b11; push(o, rnd());
        case (op_v)
            OP_LW, OP_SW: begin
                o = idle(2); o.alusrca = 1'b1; o.alusrcb = 2'b10; push(o, rnd());
                for (int i = 0; i <= wm; i++) begin
                    o = idle(op_v == OP_LW ? 3 : 5); o.iord = 1'b1;
                    o.memwrite = (op_v == OP_SW);
                    push(o, i == wm);
                end
                if (op_v == OP_LW) begin
                    o = idle(4); o.memtoreg = 1'b1; o.regwrite = 1'b1; push(o, rnd());
                end
            end
            OP_R: begin
                o = idle(6); o.alusrca = 1'b1;
                case (funct_v)
                    6'b100000: o.aluc = 3'b010;
                    6'b100010: o.aluc = 3'b110;
                    6'b100100: o.aluc = 3'b000;
                    6'b100101: o.aluc = 3'b001;
                    6'b101010: o.aluc = 3'b111;
                    default:   o.st   = 4'd0;
                endcase
                if (o.st == 4'd6) begin
                    push(o, rnd());
                    o = idle(7); o.regdst = 1'b1; o.regwrite = 1'b1; push(o, rnd());
                end
            end
            OP_BEQ, OP_BNE: begin
                o = idle(8); o.alusrca = 1'b1; o.aluc = 3'b110; o.pcsrc = 2'b01;
                o.pcen = (op_v == OP_BEQ) ? z : !z;
                push(o, rnd());
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
                o = idle(9); o.alusrca = 1'b1; o.alusrcb = 2'b10;
                o.aluc = (op_v == OP_ADDI) ? 3'b010 : (op_v == OP_ANDI) ? 3'b000 :
                         (op_v == OP_ORI)  ? 3'b001 : 3'b011;
                push(o, rnd());
                o = idle(10); o.regwrite = 1'b1; push(o, rnd());
            end
            OP_J: begin
                o = idle(11); o.pcsrc = 2'b10; o.pcen = 1'b1; push(o, rnd());
            end
            default: ;
        endcase
    endtask

    // Replay up to n queued cycles; called and returns at a falling edge.
    task automatic run_n(input int n);
        ent_t e;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            e = q.pop_front();
            mem_ready = e.mr; zero = e.z; op = e.op; funct = e.funct;
            #1;
            check($sformatf("cyc%0d_st%0d", cyc, e.o.st), 32'(sample()), 32'(e.o));
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_all();
        run_n(q.size());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        obs_t       t;
        logic [5:0] rops[10];
        logic [5:0] rfun[5];
        int         k;
        rops = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_J};
        rfun = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

        // Reset with mem_ready high: FETCH enables must still be suppressed.
        reset = 1'b1; mem_ready = 1'b1; zero = 1'b0; op = '0; funct = '0;
        @(negedge clk); #1;
        check("rst_state", 32'(dbg_state), 32'd0);
        check("rst_wen", 32'({pcen, irwrite, regwrite, memwrite}), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        mem_ready = 1'b0; reset = 1'b0;

        // lw with 2 fetch waits and 1 read wait: states 0,0,0,1,2,3,3,4.
        gen_instr(OP_LW, 6'd0, 1'b0, 2, 1); run_all();
        // Branches, both polarities of zero.
        gen_instr(OP_BNE, 6'd0, 1'b0, 0, 0); run_all();
        gen_instr(OP_BNE, 6'd0, 1'b1, 0, 0); run_all();
        gen_instr(OP_BEQ, 6'd0, 1'b0, 0, 0); run_all();
        gen_instr(OP_BEQ, 6'd0, 1'b1, 0, 0); run_all();
        // slt, xori, sw with a 3-cycle write wait.
        gen_instr(OP_R, 6'b101010, 1'b0, 0, 0); run_all();
        gen_instr(OP_XORI, 6'd0, 1'b0, 1, 0); run_all();
        gen_instr(OP_SW, 6'd0, 1'b0, 0, 3); run_all();

        // Undefined opcode.
        gen_instr(OP_BAD, 6'd0, 1'b0, 0, 0); run_all();
`ifdef MC_ILLEGAL_TRAP_EN
        t = idle(12); t.illegal = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mem_ready = rnd(); zero = rnd();
            #1;
            check($sformatf("trap%0d", i), 32'(sample()), 32'(t));
            @(negedge clk);
        end
        reset = 1'b1; #1;
        check("trap_rst", 32'({illegal, dbg_state}), 32'd0);
        @(negedge clk);
        mem_ready = 1'b0; reset = 1'b0;
`endif
        gen_instr(OP_J, 6'd0, 1'b0, 0, 0); run_all();

        // Reset mid-wait in MEMWR: strobe drops at once, no further writes.
        gen_instr(OP_SW, 6'd0, 1'b0, 0, 5); run_n(4); q.delete();
        mem_ready = 1'b0; #1;
        check("memwr_pre", 32'({memwrite, iord, dbg_state}), 32'({1'b1, 1'b1, 4'd5}));
        reset = 1'b1; #1;
        check("memwr_rst_we", 32'({memwrite, regwrite}), 32'd0);
        check("memwr_rst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        mem_ready = 1'b1; #1;
        check("rst_hold_we", 32'({irwrite, pcen, dbg_state}), 32'd0);
        @(negedge clk);
        mem_ready = 1'b0; reset = 1'b0;
        gen_instr(OP_ADDI, 6'd0, 1'b1, 0, 0); run_all();

        // Randomized instruction stream.
        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 11);
            if (k < 10) begin
                gen_instr(rops[k], rfun[$urandom_range(0, 4)], rnd(),
                          $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
`ifdef MC_ILLEGAL_TRAP_EN
                gen_instr(OP_ANDI, 6'd0, rnd(), $urandom_range(0, 2), 0);
`else
                if (k == 10) gen_instr(OP_BAD, 6'd0, rnd(), $urandom_range(0, 2), 0);
                else         gen_instr(OP_R, 6'b000111, rnd(), $urandom_range(0, 2), 0);
`endif
            end
            run_all();
        end
        // Machine must be back in FETCH after the last instruction.
        gen_instr(OP_J, 6'd0, 1'b0, 0, 0); run_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
